// File: rtl/ahbl_arbiter_pkg.sv
// rtl/ahbl_arbiter_pkg.sv - shared AHB-lite encodings and field widths for the N:1 arbiter
package ahbl_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int W_HTRANS  = 2;
  localparam int W_HSIZE   = 3;
  localparam int W_HBURST  = 3;
  localparam int W_HPROT   = 4;
  localparam int W_HMASTER = 4;

  // hwrite + htrans + hsize + hburst + hprot + hmaster + hmastlock + hexcl
  localparam int W_CTRL = 1 + W_HTRANS + W_HSIZE + W_HBURST + W_HPROT + W_HMASTER + 1 + 1;

endpackage

// File: rtl/onehot_mux.sv
// rtl/onehot_mux.sv - AND-OR multiplexer selected by a one-hot (or all-zero) vector
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) dout = dout | din[i*W +: W];
    end
  end

endmodule

// File: rtl/onehot_priority.sv
// rtl/onehot_priority.sv - isolates the lowest set bit of req (index 0 wins)
module onehot_priority #(
  parameter int W = 2
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);

  assign gnt = req & (~req + W'(1));

endmodule

// File: rtl/ahbl_arbiter.sv
// rtl/ahbl_arbiter.sv - AHB-lite N:1 fixed-priority arbiter with per-master address buffers and lock hold
module ahbl_arbiter
  import ahbl_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_PORTS-1:0]             src_hready,
  output logic [N_PORTS-1:0]             src_hready_resp,
  output logic [N_PORTS-1:0]             src_hresp,
  output logic [N_PORTS-1:0]             src_hexokay,
  input  logic [N_PORTS*W_ADDR-1:0]      src_haddr,
  input  logic [N_PORTS-1:0]             src_hwrite,
  input  logic [N_PORTS*W_HTRANS-1:0]    src_htrans,
  input  logic [N_PORTS*W_HSIZE-1:0]     src_hsize,
  input  logic [N_PORTS*W_HBURST-1:0]    src_hburst,
  input  logic [N_PORTS*W_HPROT-1:0]     src_hprot,
  input  logic [N_PORTS*W_HMASTER-1:0]   src_hmaster,
  input  logic [N_PORTS-1:0]             src_hmastlock,
  input  logic [N_PORTS-1:0]             src_hexcl,
  input  logic [N_PORTS*W_DATA-1:0]      src_hwdata,
  output logic [N_PORTS*W_DATA-1:0]      src_hrdata,
  output logic                           dst_hready,
  input  logic                           dst_hready_resp,
  input  logic                           dst_hresp,
  input  logic                           dst_hexokay,
  output logic [W_ADDR-1:0]              dst_haddr,
  output logic                           dst_hwrite,
  output logic [W_HTRANS-1:0]            dst_htrans,
  output logic [W_HSIZE-1:0]             dst_hsize,
  output logic [W_HBURST-1:0]            dst_hburst,
  output logic [W_HPROT-1:0]             dst_hprot,
  output logic [W_HMASTER-1:0]           dst_hmaster,
  output logic                           dst_hmastlock,
  output logic                           dst_hexcl,
  output logic [W_DATA-1:0]              dst_hwdata,
  input  logic [W_DATA-1:0]              dst_hrdata
);

  localparam int W_AP  = W_ADDR + W_CTRL;
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS*W_AP-1:0] live_ap;
  logic [N_PORTS*W_AP-1:0] eff_ap;
  logic [W_AP-1:0]         buf_ap [N_PORTS];
  logic [W_AP-1:0]         gnt_ap;
  logic [W_HTRANS-1:0]     gnt_htrans;

  logic [N_PORTS-1:0] live_req, req, prio_gnt, grant, gnt_d;
  logic [N_PORTS-1:0] buf_valid, buf_set, buf_clr;
  logic [IDX_W-1:0]   grant_idx, lock_owner;
  logic               lock_hold;

  // Live requests are masked during reset so the slave sees IDLE immediately.
  always_comb begin
    live_ap  = '0;
    eff_ap   = '0;
    live_req = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      live_ap[i*W_AP +: W_AP] = {src_haddr[i*W_ADDR +: W_ADDR], src_hwrite[i],
                                 src_htrans[i*W_HTRANS +: W_HTRANS],
                                 src_hsize[i*W_HSIZE +: W_HSIZE],
                                 src_hburst[i*W_HBURST +: W_HBURST],
                                 src_hprot[i*W_HPROT +: W_HPROT],
                                 src_hmaster[i*W_HMASTER +: W_HMASTER],
                                 src_hmastlock[i], src_hexcl[i]};
      eff_ap[i*W_AP +: W_AP]  = buf_valid[i] ? buf_ap[i] : live_ap[i*W_AP +: W_AP];
      live_req[i] = rst_n & src_hready[i] & src_htrans[i*W_HTRANS + 1];
    end
  end

  assign req = buf_valid | live_req;

  onehot_priority #(.W(N_PORTS)) u_prio (
    .req (req),
    .gnt (prio_gnt)
  );

  always_comb begin
    grant = prio_gnt;
    if (lock_hold && req[lock_owner]) grant = N_PORTS'(1) << lock_owner;
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  onehot_mux #(.N(N_PORTS), .W(W_AP)) u_ap_mux (
    .sel  (grant),
    .din  (eff_ap),
    .dout (gnt_ap)
  );

  assign {dst_haddr, dst_hwrite, gnt_htrans, dst_hsize, dst_hburst, dst_hprot,
          dst_hmaster, dst_hmastlock, dst_hexcl} = gnt_ap;
  assign dst_htrans = (|grant) ? gnt_htrans : HTRANS_IDLE;

  onehot_mux #(.N(N_PORTS), .W(W_DATA)) u_wdata_mux (
    .sel  (gnt_d),
    .din  (src_hwdata),
    .dout (dst_hwdata)
  );

  // A request not accepted by the slave this cycle is parked, even if it was granted.
  assign buf_clr = grant & {N_PORTS{dst_hready_resp}};
  assign buf_set = live_req & ~buf_clr & ~buf_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_d      <= '0;
      lock_hold  <= 1'b0;
      lock_owner <= '0;
      buf_valid  <= '0;
    end else begin
      if (dst_hready_resp) begin
        gnt_d      <= grant;
        lock_hold  <= dst_hmastlock & (|grant);
        lock_owner <= grant_idx;
      end
      buf_valid <= (buf_valid | buf_set) & ~buf_clr;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (buf_set[i]) buf_ap[i] <= live_ap[i*W_AP +: W_AP];
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      src_hready_resp[i] = buf_valid[i] ? 1'b0 : (gnt_d[i] ? dst_hready_resp : 1'b1);
    end
  end

  assign src_hresp   = gnt_d & {N_PORTS{dst_hresp == HRESP_ERROR}};
  assign src_hexokay = gnt_d & {N_PORTS{dst_hexokay}};
  assign src_hrdata  = {N_PORTS{dst_hrdata}};
  assign dst_hready  = dst_hready_resp;

endmodule
